// File: rtl/skel_pingpong_ram_if.sv
// skel_pingpong_ram_if: write, dual-read and bank-control bundle of the ping-pong image store
interface skel_pingpong_ram_if #(parameter int ADDR_W = 6, parameter int PIXEL_W = 8);
    logic               we;
    logic               harris_bit;
    logic [ADDR_W-1:0]  wr_addr;
    logic [PIXEL_W-1:0] wr_data;
    logic [ADDR_W-1:0]  rd_addr_a;
    logic [ADDR_W-1:0]  rd_addr_b;
    logic [PIXEL_W-1:0] rd_data_a;
    logic [PIXEL_W-1:0] rd_data_b;
    logic               swap_req;
    logic               swap_ack;
    logic               clr_req;
    logic               busy;
    logic               wr_drop;
    logic               active_bank;
    modport master (
        output we, harris_bit, wr_addr, wr_data, rd_addr_a, rd_addr_b, swap_req, clr_req,
        input  rd_data_a, rd_data_b, swap_ack, busy, wr_drop, active_bank
    );
    modport slave (
        input  we, harris_bit, wr_addr, wr_data, rd_addr_a, rd_addr_b, swap_req, clr_req,
        output rd_data_a, rd_data_b, swap_ack, busy, wr_drop, active_bank
    );
endinterface

// File: rtl/skel_pingpong_ram.sv
// skel_pingpong_ram: double-banked NxN pixel store with decimated masked writes, clear sweep and swap
module skel_pingpong_ram #(
    parameter int   N           = 8,
    parameter int   PIXEL_W     = 8,
    parameter int   ADDR_W      = 6,
    parameter int   WR_DIV      = 2,
    parameter logic HARRIS_KEEP = 1'b0
) (
    input logic              clk,
    input logic              rst,
    skel_pingpong_ram_if.slave bus
);
    localparam int DEPTH = N * N;
    localparam int IW    = $clog2(DEPTH);
    localparam int PH_W  = WR_DIV > 1 ? $clog2(WR_DIV) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t             state_q, state_d;
    logic [ADDR_W:0]    sweep_q, sweep_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               active_bank_q, active_bank_d;
    logic               swap_ack_q, swap_ack_d;
    logic               wr_drop_q, wr_drop_d;
    logic [PIXEL_W-1:0] rd_data_a_q, rd_data_a_d;
    logic [PIXEL_W-1:0] rd_data_b_q, rd_data_b_d;
    logic [PIXEL_W-1:0] mem_wdata;
    logic [IW-1:0]      mem_waddr;
    logic               mem_we, wr_ok, swap;
    logic [PIXEL_W-1:0] mem [2][DEPTH];
    always_comb begin
        wr_ok         = bus.we && state_q == IDLE && phase_q == '0 && bus.wr_addr <= LAST;
        swap          = state_q == IDLE && bus.swap_req && !bus.clr_req;
        wr_drop_d     = bus.we && !wr_ok;
        swap_ack_d    = swap;
        active_bank_d = active_bank_q ^ swap;
        phase_d       = swap || phase_q == PH_W'(WR_DIV - 1) ? '0 : phase_q + 1'b1;
        state_d       = state_q;
        sweep_d       = sweep_q + 1'b1;
        if (state_q == IDLE) begin
            state_d = bus.clr_req ? CLEAR : IDLE;
            sweep_d = '0;
        end else if (sweep_q == {1'b0, LAST}) begin
            state_d = IDLE;
        end
        // the sweep owns the write port; user writes are already rejected while clearing
        mem_we      = state_q == CLEAR || wr_ok;
        mem_waddr   = state_q == CLEAR ? sweep_q[IW-1:0] : bus.wr_addr[IW-1:0];
        mem_wdata   = state_q == CLEAR || bus.harris_bit != HARRIS_KEEP ? '0 : bus.wr_data;
        rd_data_a_d = bus.rd_addr_a <= LAST ? mem[active_bank_q][bus.rd_addr_a[IW-1:0]] : '0;
        rd_data_b_d = bus.rd_addr_b <= LAST ? mem[active_bank_q][bus.rd_addr_b[IW-1:0]] : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sweep_q       <= '0;
            phase_q       <= '0;
            active_bank_q <= 1'b0;
            swap_ack_q    <= 1'b0;
            wr_drop_q     <= 1'b0;
            rd_data_a_q   <= '0;
            rd_data_b_q   <= '0;
        end else begin
            state_q       <= state_d;
            sweep_q       <= sweep_d;
            phase_q       <= phase_d;
            active_bank_q <= active_bank_d;
            swap_ack_q    <= swap_ack_d;
            wr_drop_q     <= wr_drop_d;
            rd_data_a_q   <= rd_data_a_d;
            rd_data_b_q   <= rd_data_b_d;
        end
    end
    // write bank is the pre-edge ~active_bank, so a write alongside a swap lands in the new read bank
    always_ff @(posedge clk) begin
        if (mem_we) mem[~active_bank_q][mem_waddr] <= mem_wdata;
    end
    assign bus.rd_data_a   = rd_data_a_q;
    assign bus.rd_data_b   = rd_data_b_q;
    assign bus.swap_ack    = swap_ack_q;
    assign bus.wr_drop     = wr_drop_q;
    assign bus.active_bank = active_bank_q;
    assign bus.busy        = state_q == CLEAR;
endmodule

// File: tb/tb_skel_pingpong_ram.sv
// tb_skel_pingpong_ram: directed plan plus random traffic on two configurations against a bank/array model
module tb_skel_pingpong_ram;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    skel_pingpong_ram_if #(.ADDR_W(6), .PIXEL_W(8)) ia ();
    skel_pingpong_ram_if #(.ADDR_W(7), .PIXEL_W(8)) ib ();
    skel_pingpong_ram #(.N(8), .PIXEL_W(8), .ADDR_W(6), .WR_DIV(2), .HARRIS_KEEP(1'b0))
        u_a (.clk(clk), .rst(rst), .bus(ia));
    skel_pingpong_ram #(.N(8), .PIXEL_W(8), .ADDR_W(7), .WR_DIV(1), .HARRIS_KEEP(1'b0))
        u_b (.clk(clk), .rst(rst), .bus(ib));
    logic       we[2], hb[2], sw[2], cr[2];
    logic [6:0] wa[2], ra[2], rb[2];
    logic [7:0] wd[2];
    logic [7:0] oa[2], ob[2];
    logic       ack[2], drop[2], bsy[2], bank[2];
    assign ia.we = we[0];  assign ia.harris_bit = hb[0]; assign ia.swap_req = sw[0]; assign ia.clr_req = cr[0];
    assign ia.wr_addr = wa[0][5:0]; assign ia.rd_addr_a = ra[0][5:0]; assign ia.rd_addr_b = rb[0][5:0];
    assign ia.wr_data = wd[0];
    assign ib.we = we[1];  assign ib.harris_bit = hb[1]; assign ib.swap_req = sw[1]; assign ib.clr_req = cr[1];
    assign ib.wr_addr = wa[1]; assign ib.rd_addr_a = ra[1]; assign ib.rd_addr_b = rb[1];
    assign ib.wr_data = wd[1];
    assign oa[0] = ia.rd_data_a; assign ob[0] = ia.rd_data_b; assign ack[0] = ia.swap_ack;
    assign drop[0] = ia.wr_drop; assign bsy[0] = ia.busy; assign bank[0] = ia.active_bank;
    assign oa[1] = ib.rd_data_a; assign ob[1] = ib.rd_data_b; assign ack[1] = ib.swap_ack;
    assign drop[1] = ib.wr_drop; assign bsy[1] = ib.busy; assign bank[1] = ib.active_bank;
    logic [7:0] mem [2][2][128];
    int         clr_left[2], since[2];
    logic       act[2], e_ack[2], e_drop[2];
    logic [7:0] e_a[2], e_b[2];
    int         checks = 0, errors = 0, cyc = 0;
    function automatic int eff(int i, logic [6:0] a);
        return i == 0 ? int'(a[5:0]) : int'(a);
    endfunction
    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; e_ack[i] = 0; e_drop[i] = 0; e_a[i] = 0; e_b[i] = 0;
            clr_left[i] = 0; since[i] = 0;
        end
    endtask
    task automatic step(int i);
        int  w, a, b, div;
        bit  idle, ok;
        w = eff(i, wa[i]); a = eff(i, ra[i]); b = eff(i, rb[i]);
        div = i == 0 ? 2 : 1;
        idle = clr_left[i] == 0;
        ok = we[i] && idle && since[i] % div == 0 && w < 64;
        e_drop[i] = we[i] && !ok;
        e_a[i] = a < 64 ? mem[i][act[i]][a] : 8'h00;
        e_b[i] = b < 64 ? mem[i][act[i]][b] : 8'h00;
        if (ok) mem[i][!act[i]][w] = hb[i] == 1'b0 ? wd[i] : 8'h00;
        if (!idle) begin
            mem[i][!act[i]][64 - clr_left[i]] = 8'h00;
            clr_left[i]--;
        end else if (cr[i]) clr_left[i] = 64;
        e_ack[i] = idle && sw[i] && !cr[i];
        if (e_ack[i]) act[i] = !act[i];
        since[i] = e_ack[i] ? 0 : since[i] + 1;
    endtask
    task automatic check(int i);
        logic [19:0] got, exp;
        got = {oa[i], ob[i], ack[i], drop[i], bsy[i], bank[i]};
        exp = {e_a[i], e_b[i], e_ack[i], e_drop[i], clr_left[i] != 0, act[i]};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL model cyc%0d inst%0d observed %h expected %h", cyc, i, got, exp);
        end
    endtask
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cycle();
        if (!rst) for (int i = 0; i < 2; i++) step(i);
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) check(i);
    endtask
    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            we[i] = 0; hb[i] = 0; sw[i] = 0; cr[i] = 0; wa[i] = 0; ra[i] = 0; rb[i] = 0; wd[i] = 0;
        end
        rst = 1'b1;
        mreset();
        repeat (2) cycle();
        chk("reset_bank", 32'(bank[0]), 0);
        chk("reset_rd", 32'({oa[0], ob[1]}), 0);
        rst = 1'b0;
        // zero both banks of both instances, ending on a swap so phase is 0
        for (int k = 0; k < 2; k++) begin
            cr[0] = 1; cr[1] = 1; cycle(); cr[0] = 0; cr[1] = 0;
            repeat (64) cycle();
            sw[0] = 1; sw[1] = 1; cycle(); sw[0] = 0; sw[1] = 0;
        end
        we[0] = 1; hb[0] = 0; wd[0] = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            wa[0] = 7'(k); cycle();
            chk("dec_drop", 32'(drop[0]), 32'(k % 2));
        end
        we[0] = 0; sw[0] = 1; cycle(); sw[0] = 0;
        ra[0] = 2; rb[0] = 1; cycle();
        chk("dec_rd2", 32'(oa[0]), 32'hA5);
        chk("dec_rd1", 32'(ob[0]), 0);
        for (int k = 0; k < 2; k++) begin
            we[1] = 1; wa[1] = 5; wd[1] = 8'hFF; hb[1] = k == 0; cycle();
            we[1] = 0; sw[1] = 1; cycle(); sw[1] = 0;
            ra[1] = 5; cycle();
            chk("harris_rd5", 32'(oa[1]), k == 0 ? 32'h00 : 32'hFF);
        end
        sw[0] = 1; cycle();
        chk("swap_pre_bank", 32'(bank[0]), 0);
        we[0] = 1; wa[0] = 10; wd[0] = 8'h3C; hb[0] = 0; cycle();
        sw[0] = 0; we[0] = 0;
        chk("swap_bank", 32'(bank[0]), 1);
        chk("swap_ack", 32'(ack[0]), 1);
        ra[0] = 10; cycle();
        chk("swap_rd10", 32'(oa[0]), 32'h3C);
        chk("swap_ack_pulse", 32'(ack[0]), 0);
        we[0] = 1; wd[0] = 8'h77;
        for (int a = 0; a < 64; a++) begin
            wa[0] = 7'(a); cycle(); cycle();
        end
        we[0] = 0; cr[0] = 1; cycle(); cr[0] = 0;
        ra[0] = 10;
        n = 0;
        while (bsy[0] && n < 100) begin
            n++;
            we[0] = n == 10; sw[0] = n == 20; rb[0] = 7'($urandom_range(63));
            cycle();
            if (n == 10) chk("clr_we_drop", 32'(drop[0]), 1);
            if (n == 20) chk("clr_no_ack", 32'(ack[0]), 0);
            we[0] = 0; sw[0] = 0;
        end
        chk("clr_busy_len", 32'(n), 64);
        chk("clr_read_bank", 32'(oa[0]), 32'h3C);
        sw[0] = 1; cycle(); sw[0] = 0;
        for (int a = 0; a < 64; a++) begin
            ra[0] = 7'(a); cycle();
            if (a > 0 && a % 9 == 0) chk("clr_zero", 32'(oa[0]), 0);
        end
        we[1] = 1; wa[1] = 64; wd[1] = 8'h55; hb[1] = 0; cycle(); we[1] = 0;
        chk("oor_drop", 32'(drop[1]), 1);
        ra[1] = 100; cycle();
        chk("oor_rd", 32'(oa[1]), 0);
        ra[0] = 3; rb[0] = 10;
        cr[0] = 1; cycle(); cr[0] = 0;
        repeat (20) cycle();
        #1;
        rst = 1'b1;
        mreset();
        #1;
        chk("arst_busy", 32'(bsy[0]), 0);
        chk("arst_bank", 32'(bank[0]), 0);
        chk("arst_rd", 32'({oa[0], ob[0]}), 0);
        cycle();
        rst = 1'b0;
        we[0] = 1; wa[0] = 7; wd[0] = 8'h99; hb[0] = 0; cycle(); we[0] = 0;
        chk("arst_wr_ok", 32'(drop[0]), 0);
        sw[0] = 1; cycle(); sw[0] = 0;
        ra[0] = 7; cycle();
        chk("arst_rd7", 32'(oa[0]), 32'h99);
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 2; i++) begin
                we[i] = 1'($urandom_range(1));
                hb[i] = 1'($urandom_range(1));
                wa[i] = 7'($urandom_range(i == 0 ? 63 : 79));
                wd[i] = 8'($urandom);
                ra[i] = 7'($urandom_range(i == 0 ? 63 : 127));
                rb[i] = 7'($urandom_range(i == 0 ? 63 : 127));
                sw[i] = $urandom_range(9) == 0;
                cr[i] = $urandom_range(99) == 0;
            end
            cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/skel_pingpong_ram.md
Name: skel_pingpong_ram

Overview:
- Double-banked (ping-pong) N×N pixel image store for the iterative skeletonization datapath.
- One bank is the read image for the current thinning pass; the other bank receives the thinned result.
- A swap exchanges the two banks between passes.
- Adds over the single-bank store: configurable write decimation, Harris masking on write, a hardware bank-clear sweep, registered dual reads and out-of-range protection.

Parameters:
- N, 8, image side length; each bank holds N*N pixels.
- PIXEL_W, 8, pixel width in bits.
- ADDR_W, 6, address width; must satisfy 2**ADDR_W >= N*N.
- WR_DIV, 2, write decimation. A write is accepted only when the phase counter is 0. 1 = every cycle; legal range 1..16.
- HARRIS_KEEP, 1'b0, harris_bit value that lets wr_data through; any other value writes 0.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  write request.
- harris_bit  in  1  Harris mask qualifier for the current write.
- wr_addr  in  ADDR_W  write address into the write bank.
- wr_data  in  PIXEL_W  write pixel.
- rd_addr_a  in  ADDR_W  read port A address into the read bank.
- rd_addr_b  in  ADDR_W  read port B address into the read bank.
- rd_data_a  out  PIXEL_W  registered read data, port A.
- rd_data_b  out  PIXEL_W  registered read data, port B.
- swap_req  in  1  request bank exchange.
- swap_ack  out  1  one-cycle pulse confirming a swap.
- clr_req  in  1  request zero-fill of the write bank.
- busy  out  1  high while a clear sweep is running.
- wr_drop  out  1  one-cycle pulse: the previous cycle's write request was rejected.
- active_bank  out  1  index of the current read bank; the write bank is ~active_bank.

Behaviour:
- Reset values: active_bank=0, rd_data_a=rd_data_b=0, swap_ack=0, busy=0, wr_drop=0, phase=0, state=IDLE.
- Reset does not initialise RAM contents. Reset asserted mid-sweep aborts the clear immediately; words already cleared stay 0, the rest keep their old values.
- Phase counter: counts 0..WR_DIV-1 and wraps every cycle. It is forced to 0 on the cycle after a swap.
- Write acceptance: we=1 is accepted only when all of these hold:
  - state is IDLE;
  - phase is 0;
  - wr_addr < N*N.
- Accepted write: mem[~active_bank][wr_addr] is loaded with wr_data if harris_bit==HARRIS_KEEP, otherwise with 0.
- Rejected write (any condition fails): no memory change, and wr_drop pulses high on the next cycle.
- Reads:
  - Latency is 1 cycle. rd_data_x <= mem[active_bank][rd_addr_x] every cycle, whatever the state.
  - An address >= N*N returns 0.
  - Both ports may use the same address.
  - Reads and writes target different banks, so there is no read/write collision.
- FSM states are IDLE and CLEAR.
- IDLE + clr_req=1:
  - Go to CLEAR with sweep counter=0 and busy=1 from the next cycle.
  - clr_req has priority over swap_req in the same cycle; the swap is ignored and no ack is given.
- IDLE + swap_req=1 (and clr_req=0):
  - active_bank toggles at that edge; swap_ack pulses on the following cycle.
  - A write accepted in the same cycle lands in the pre-swap write bank, so it is readable right after the swap.
  - swap_req held high toggles the bank every cycle; upstream pulses it.
- CLEAR:
  - Each cycle writes 0 to mem[~active_bank][sweep] and increments sweep.
  - After address N*N-1 is written, return to IDLE; busy falls on the next cycle.
  - The sweep takes exactly N*N cycles of busy=1.
  - we is rejected (wr_drop) throughout. swap_req and clr_req are ignored with no ack and no restart.
  - The read bank is untouched.
- Sweep counter width is ADDR_W+1, so terminal-count detection has no wrap hazard when N*N == 2**ADDR_W.

Test Plan:
- Reset then decimation, N=8, WR_DIV=2: hold we=1, harris_bit=0, wr_data=8'hA5 to addresses 0..3 on consecutive cycles. Required:
  - addresses 0 and 2 accepted; addresses 1 and 3 dropped, with a wr_drop pulse on the cycle after each.
  - after a swap, a read of address 2 returns 8'hA5 one cycle after the address is applied.
- Harris mask, WR_DIV=1: write 8'hFF to address 5 with harris_bit=1, then swap. Required: a read of address 5 returns 8'h00. The same write with harris_bit=0 returns 8'hFF.
- Swap with same-cycle write: write 8'h3C to address 10 in the same cycle as swap_req. Required: active_bank 0→1, swap_ack high on the next cycle, and rd_addr_a=10 returns 8'h3C.
- Clear sweep:
  - fill the write bank with 8'h77, then pulse clr_req;
  - required: busy high for exactly 64 cycles and all 64 addresses read 0 after the next swap;
  - a we and a swap_req issued mid-sweep give a wr_drop pulse and no swap_ack respectively;
  - read-bank data is unchanged during the sweep.
- Out of range, ADDR_W=7, N=8: write to address 64, read address 100. Required: wr_drop pulses and rd_data is 0.
- Async reset mid-clear: assert rst at sweep address 20 without a clock edge. Required: busy=0, active_bank=0 and rd_data=0 immediately; after release, normal writes are accepted.
